// File: rtl/sram_arbiter_if.sv
// Requester channel of the SRAM arbiter: op/addr/wdata in, done pulse and read data back.
// The requester is the master; the arbiter takes the slave modport.
interface sram_arbiter_if;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        opdone;
    logic [31:0] rdata;

    modport master (
        output op,
        output addr,
        output wdata,
        input  opdone,
        input  rdata
    );

    modport slave (
        input  op,
        input  addr,
        input  wdata,
        output opdone,
        output rdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between two requesters.
// Sequences each access into the SRAM's registered timing and returns a done pulse.
module sram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    sram_arbiter_if.slave     p0,
    sram_arbiter_if.slave     p1,
    output logic              sram_csb,
    output logic              sram_web,
    output logic [3:0]        sram_wmask,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_din,
    input  logic [31:0]       sram_dout,
    output logic              busy,
    output logic [1:0]        grant,
    output logic              oob_err,
    input  logic              oob_clr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [2:0]  LAT     = 3'(RD_LAT);

    state_t state_q, state_d;

    // last_q: 1 means port 1 was the last owner
    logic              last_q, last_d;
    logic              port_q, port_d;
    logic              wr_q, wr_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              csb_q, csb_d;
    logic              web_q, web_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       din_q, din_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic [31:0]       rd0_q, rd0_d;
    logic [31:0]       rd1_q, rd1_d;
    logic              busy_q, busy_d;
    logic [1:0]        grant_q, grant_d;
    logic              oob_q, oob_d;

    logic              v0, v1;
    logic              sel;
    logic [1:0]        sel_op;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;
    logic              oob_hit;
    logic              oob_set;

    // Request decode and round-robin pick; op 01 and 11 are the only valid ops
    always_comb begin
        v0        = p0.op[0];
        v1        = p1.op[0];
        sel       = (v0 & v1) ? ~last_q : v1;
        sel_op    = sel ? p1.op : p0.op;
        sel_addr  = sel ? p1.addr : p0.addr;
        sel_wdata = sel ? p1.wdata : p0.wdata;
        oob_hit   = sel_addr >= DEPTH_W;
    end

    // Next-state and registered-output logic of the access sequencer
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        port_d  = port_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        csb_d   = 1'b1;
        web_d   = 1'b1;
        addr_d  = addr_q;
        din_d   = din_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        grant_d = grant_q;
        oob_set = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                grant_d = 2'b00;
                if (v0 | v1) begin
                    port_d  = sel;
                    wr_d    = sel_op[1];
                    last_d  = sel;
                    grant_d = sel ? 2'b10 : 2'b01;
                    if (oob_hit) begin
                        oob_set = 1'b1;
                        state_d = S_DONE;
                        done0_d = ~sel;
                        done1_d = sel;
                        if (!sel_op[1]) begin
                            if (sel) rd1_d = '0;
                            else     rd0_d = '0;
                        end
                    end else begin
                        csb_d   = 1'b0;
                        web_d   = ~sel_op[1];
                        addr_d  = sel_addr[ADDR_W-1:0];
                        din_d   = sel_wdata;
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (wr_q) begin
                    state_d = S_DONE;
                    done0_d = ~port_q;
                    done1_d = port_q;
                end else begin
                    cnt_d   = LAT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd1) begin
                    if (port_q) rd1_d = sram_dout;
                    else        rd0_d = sram_dout;
                    state_d = S_DONE;
                    done0_d = ~port_q;
                    done1_d = port_q;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
            end
        endcase

        oob_d  = oob_set | (oob_q & ~oob_clr);
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            port_q  <= 1'b0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            addr_q  <= '0;
            din_q   <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            busy_q  <= 1'b0;
            grant_q <= 2'b00;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            port_q  <= port_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
            busy_q  <= busy_d;
            grant_q <= grant_d;
            oob_q   <= oob_d;
        end
    end

    assign sram_csb   = csb_q;
    assign sram_web   = web_q;
    assign sram_wmask = 4'b1111;
    assign sram_addr  = addr_q;
    assign sram_din   = din_q;
    assign p0.opdone  = done0_q;
    assign p1.opdone  = done1_q;
    assign p0.rdata   = rd0_q;
    assign p1.rdata   = rd1_q;
    assign busy       = busy_q;
    assign grant      = grant_q;
    assign oob_err    = oob_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: random requesters, an SRAM model, and a
// transaction-level reference that predicts every access window.
module tb_sram_arbiter;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;
    localparam int RD_LAT = 3;
    localparam int NCYC   = 3000;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hold;
    } req_t;

    logic              clk;
    logic              reset;
    logic              oob_clr;
    logic              sram_csb;
    logic              sram_web;
    logic [3:0]        sram_wmask;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_din;
    logic [31:0]       sram_dout;
    logic              busy;
    logic [1:0]        grant;
    logic              oob_err;
    logic              mem_clr;

    sram_arbiter_if p0_if ();
    sram_arbiter_if p1_if ();

    sram_arbiter #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .p0         (p0_if),
        .p1         (p1_if),
        .sram_csb   (sram_csb),
        .sram_web   (sram_web),
        .sram_wmask (sram_wmask),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout),
        .busy       (busy),
        .grant      (grant),
        .oob_err    (oob_err),
        .oob_clr    (oob_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM macro: samples on the edge, read data after RD_LAT edges
    logic [31:0] smem [DEPTH];
    logic [31:0] pipe [RD_LAT];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) smem[i] <= '0;
        end else if (!sram_csb && !sram_web) begin
            smem[sram_addr] <= sram_din;
        end
        for (int i = RD_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        if (!sram_csb && sram_web) pipe[0] <= smem[sram_addr];
    end

    assign sram_dout = pipe[RD_LAT-1];

    int errs;
    int checks;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic req_t rnd_req();
        req_t r;
        int   k;
        k       = int'($urandom_range(0, 15));
        r.hold  = 0;
        r.wdata = $urandom;
        if ($urandom_range(0, 1) == 1) r.addr = 32'($urandom_range(0, 15));
        else if ($urandom_range(0, 7) == 0) r.addr = 32'(DEPTH - 1);
        else r.addr = 32'($urandom_range(0, DEPTH - 1));
        if (k == 0) begin
            r.op   = 2'b10;
            r.hold = int'($urandom_range(1, 4));
        end else if (k == 1) begin
            r.op = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b01;
            if ($urandom_range(0, 1) == 1) r.addr = 32'(DEPTH + $urandom_range(0, 2));
            else r.addr = $urandom | 32'h8000_0000;
        end else if (k < 8) begin
            r.op = 2'b11;
        end else begin
            r.op = 2'b01;
        end
        return r;
    endfunction

    // reference model state
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_rd [2];
    req_t        cur [2];
    bit          has [2];
    bit          drop_next [2];
    req_t        q0 [$];
    req_t        q1 [$];
    int          t;
    int          g;
    int          d;
    int          free_at;
    int          last;
    int          a_port;
    bit          active;
    bit          a_wr;
    bit          a_oob;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    bit          oob_exp;
    bit          rst_prev;
    bit          forced;

    initial begin
        bit          in_acc;
        bit          e_csb;
        bit          e_web;
        bit          e_done [2];
        bit          dropped;
        bit          rst;
        bit          nxt;
        bit          v0;
        bit          v1;
        int          w;
        logic [1:0]  e_grant;
        req_t        r;

        errs    = 0;
        checks  = 0;
        t       = 0;
        g       = -10;
        d       = -10;
        a_port  = 0;
        a_wr    = 0;
        a_oob   = 0;
        a_addr  = '0;
        a_wdata = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        reset        = 1'b1;
        mem_clr      = 1'b1;
        oob_clr      = 1'b0;
        p0_if.op     = 2'b00;
        p0_if.addr   = '0;
        p0_if.wdata  = '0;
        p1_if.op     = 2'b00;
        p1_if.addr   = '0;
        p1_if.wdata  = '0;
        active       = 0;
        free_at      = 0;
        last         = 1;
        oob_exp      = 0;
        rst_prev     = 1;
        forced       = 0;
        for (int p = 0; p < 2; p++) begin
            exp_rd[p]    = '0;
            has[p]       = 0;
            drop_next[p] = 0;
        end

        q0.push_back('{op: 2'b11, addr: 32'd5, wdata: 32'hDEADBEEF, hold: 0});
        q0.push_back('{op: 2'b01, addr: 32'd5, wdata: 32'h0, hold: 0});
        q0.push_back('{op: 2'b10, addr: 32'd9, wdata: 32'h0, hold: 3});
        q0.push_back('{op: 2'b01, addr: 32'd6, wdata: 32'h0, hold: 0});
        q1.push_back('{op: 2'b01, addr: 32'd5, wdata: 32'h0, hold: 0});
        q1.push_back('{op: 2'b11, addr: 32'd300, wdata: 32'h12345678, hold: 0});
        q1.push_back('{op: 2'b01, addr: 32'd300, wdata: 32'h0, hold: 0});
        q1.push_back('{op: 2'b11, addr: 32'd6, wdata: 32'hCAFEF00D, hold: 0});

        while (t < NCYC) begin
            @(posedge clk);
            #1;
            t++;

            in_acc    = active && t > g && t <= d;
            e_grant   = in_acc ? (a_port == 1 ? 2'b10 : 2'b01) : 2'b00;
            e_csb     = !(active && t == g + 1 && !a_oob);
            e_web     = !(active && t == g + 1 && !a_oob && a_wr);
            e_done[0] = active && t == d && a_port == 0;
            e_done[1] = active && t == d && a_port == 1;
            if (active && t == d && !a_wr)
                exp_rd[a_port] = a_oob ? 32'h0 : ref_mem[int'(a_addr)];

            check("busy", 32'(busy), 32'(in_acc));
            check("grant", 32'(grant), 32'(e_grant));
            check("sram_csb", 32'(sram_csb), 32'(e_csb));
            check("sram_web", 32'(sram_web), 32'(e_web));
            check("sram_wmask", 32'(sram_wmask), 32'hF);
            check("p0_opdone", 32'(p0_if.opdone), 32'(e_done[0]));
            check("p1_opdone", 32'(p1_if.opdone), 32'(e_done[1]));
            check("p0_rdata", p0_if.rdata, exp_rd[0]);
            check("p1_rdata", p1_if.rdata, exp_rd[1]);
            check("oob_err", 32'(oob_err), 32'(oob_exp));
            if (!e_csb) begin
                check("sram_addr", 32'(sram_addr), 32'(a_addr[ADDR_W-1:0]));
                if (a_wr) check("sram_din", sram_din, a_wdata);
            end
            if (rst_prev) begin
                check("rst_sram_addr", 32'(sram_addr), 32'h0);
                check("rst_sram_din", sram_din, 32'h0);
            end

            mem_clr = 1'b0;
            for (int p = 0; p < 2; p++) begin
                dropped = drop_next[p];
                if (dropped) has[p] = 0;
                drop_next[p] = e_done[p];
                if (has[p] && cur[p].op == 2'b10) begin
                    if (cur[p].hold <= 1) has[p] = 0;
                    else cur[p].hold--;
                end
                if (!has[p] && !dropped) begin
                    if (p == 0 && q0.size() > 0) begin
                        cur[p] = q0.pop_front();
                        has[p] = 1;
                    end else if (p == 1 && q1.size() > 0) begin
                        cur[p] = q1.pop_front();
                        has[p] = 1;
                    end else if (t > 80 && $urandom_range(0, 2) != 0) begin
                        r      = rnd_req();
                        cur[p] = r;
                        has[p] = 1;
                    end
                end
            end

            rst = (t < 3) || (t > 80 && $urandom_range(0, 299) == 0);
            if (!forced && t > 80 && active && !a_wr && !a_oob && t == g + 2) begin
                forced = 1;
                rst    = 1;
            end
            oob_clr = (t > 80 && $urandom_range(0, 4) == 0);
            reset   = rst;

            p0_if.op    = has[0] ? cur[0].op : 2'b00;
            p0_if.addr  = has[0] ? cur[0].addr : 32'h0;
            p0_if.wdata = has[0] ? cur[0].wdata : 32'h0;
            p1_if.op    = has[1] ? cur[1].op : 2'b00;
            p1_if.addr  = has[1] ? cur[1].addr : 32'h0;
            p1_if.wdata = has[1] ? cur[1].wdata : 32'h0;

            if (rst) begin
                active    = 0;
                free_at   = t + 1;
                last      = 1;
                exp_rd[0] = '0;
                exp_rd[1] = '0;
                oob_exp   = 0;
                rst_prev  = 1;
            end else begin
                rst_prev = 0;
                nxt      = oob_exp && !oob_clr;
                if (t >= free_at) begin
                    v0 = has[0] && (cur[0].op == 2'b01 || cur[0].op == 2'b11);
                    v1 = has[1] && (cur[1].op == 2'b01 || cur[1].op == 2'b11);
                    if (v0 || v1) begin
                        w       = (v0 && v1) ? 1 - last : (v1 ? 1 : 0);
                        active  = 1;
                        g       = t;
                        a_port  = w;
                        a_wr    = (cur[w].op == 2'b11);
                        a_addr  = cur[w].addr;
                        a_wdata = cur[w].wdata;
                        a_oob   = (cur[w].addr >= 32'(DEPTH));
                        if (a_oob) d = t + 1;
                        else if (a_wr) d = t + 2;
                        else d = t + 2 + RD_LAT;
                        free_at = d + 1;
                        last    = w;
                        if (a_oob) nxt = 1;
                        if (a_wr && !a_oob) ref_mem[int'(a_addr)] = a_wdata;
                    end
                end
                oob_exp = nxt;
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
